// File: rtl/gf_vec_add_stage_pkg.sv
// Shared definitions for the GF(256) vector-add stage: address-width macro,
// word-width derivation and FSM state encoding.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package gf_vec_add_stage_pkg;

    localparam int GF_BITS = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic int proc_size(input int n_gf);
        return n_gf * GF_BITS;
    endfunction

endpackage

// File: rtl/gf_vec_add_stage_rd_lat_delay.sv
// Fixed-depth shift register that tracks {valid, addr} of outstanding reads
// so the write stage knows which word the memories are returning.
module rd_lat_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_tail,
    output logic         o_empty
);

    logic [W-1:0] stage_q [DEPTH];

    // shift register; the MSB of each stage is the valid bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // empty when no stage holds a pending read
    always_comb begin
        o_empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            o_empty = o_empty & ~stage_q[i][W-1];
        end
    end

    assign o_tail = stage_q[DEPTH-1];

endmodule

// File: rtl/gf_vec_add_stage.sv
// y = H*s_A + s_B: streams the multiplier result and s_B word by word,
// XORs them and writes y, one word per cycle.
module gf_vec_add_stage
    import gf_vec_add_stage_pkg::*;
#(
    parameter  int VEC_SIZE_BYTES = 8,
    parameter  int N_GF           = 2,
    parameter  int RD_LAT         = 1,
    localparam int PROC_SIZE      = proc_size(N_GF),
    localparam int WORDS          = VEC_SIZE_BYTES / N_GF,
    localparam int ADDR_W         = `CLOG2(WORDS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ADDR_W-1:0]    o_res_addr,
    input  logic [PROC_SIZE-1:0] i_res,
    output logic [ADDR_W-1:0]    o_sb_addr,
    input  logic [PROC_SIZE-1:0] i_sb,
    output logic [ADDR_W-1:0]    o_y_addr,
    output logic [PROC_SIZE-1:0] o_y,
    output logic                 o_y_wen
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                y_wen_q, y_wen_d;
    logic [ADDR_W-1:0]   y_addr_q, y_addr_d;
    logic [PROC_SIZE-1:0] y_q, y_d;

    logic [ADDR_W:0]     dl_in;
    logic [ADDR_W:0]     dl_tail;
    logic                dl_empty;

    assign dl_in = {(state_q == S_READ), addr_q};

    rd_lat_delay #(
        .DEPTH (RD_LAT),
        .W     (ADDR_W + 1)
    ) u_rd_lat_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (dl_in),
        .o_tail  (dl_tail),
        .o_empty (dl_empty)
    );

    // control FSM and read-address counter
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (i_start) begin
                    state_d = S_READ;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (dl_empty) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // write stage: GF(256) addition is a plain XOR; y holds between writes
    always_comb begin
        y_wen_d  = 1'b0;
        y_addr_d = y_addr_q;
        y_d      = y_q;
        if (dl_tail[ADDR_W]) begin
            y_wen_d  = 1'b1;
            y_addr_d = dl_tail[ADDR_W-1:0];
            y_d      = i_res ^ i_sb;
        end else begin
            y_wen_d  = 1'b0;
        end
    end

    // state and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_wen_q  <= 1'b0;
            y_addr_q <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            y_wen_q  <= y_wen_d;
            y_addr_q <= y_addr_d;
            y_q      <= y_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_res_addr = addr_q;
    assign o_sb_addr  = addr_q;
    assign o_y_addr   = y_addr_q;
    assign o_y        = y_q;
    assign o_y_wen    = y_wen_q;

endmodule

// File: tb/tb_gf_vec_add_stage.sv
// Directed/randomized bench for gf_vec_add_stage: three instances (default,
// RD_LAT=3, 4-element words) with memory models and a spec-level reference.
module tb_gf_vec_add_stage;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   passes = 0;
    int   fails = 0;

    logic start0, start1, start2;
    logic busy0, busy1, busy2;
    logic done0, done1, done2;
    logic [1:0]  ra0, sa0, ya0, ra1, sa1, ya1, ra2, sa2, ya2;
    logic [15:0] res0, sb0, y0, res1, sb1, y1;
    logic [31:0] res2, sb2, y2;
    logic wen0, wen1, wen2;

    logic [31:0] res_m [3][4];
    logic [31:0] sb_m  [3][4];

    typedef struct { int id; int addr; logic [31:0] y; int cyc; } wr_t;
    typedef struct { int id; int cyc; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    gf_vec_add_stage dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .o_busy(busy0), .o_done(done0),
        .o_res_addr(ra0), .i_res(res0), .o_sb_addr(sa0), .i_sb(sb0),
        .o_y_addr(ya0), .o_y(y0), .o_y_wen(wen0)
    );

    gf_vec_add_stage #(.RD_LAT(3)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .o_busy(busy1), .o_done(done1),
        .o_res_addr(ra1), .i_res(res1), .o_sb_addr(sa1), .i_sb(sb1),
        .o_y_addr(ya1), .o_y(y1), .o_y_wen(wen1)
    );

    gf_vec_add_stage #(.VEC_SIZE_BYTES(16), .N_GF(4)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .o_busy(busy2), .o_done(done2),
        .o_res_addr(ra2), .i_res(res2), .o_sb_addr(sa2), .i_sb(sb2),
        .o_y_addr(ya2), .o_y(y2), .o_y_wen(wen2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory models: data appears RD_LAT cycles after the address
    logic [1:0] r0_d, s0_d, r2_d, s2_d;
    logic [1:0] r1_d [3];
    logic [1:0] s1_d [3];
    always @(posedge clk) begin
        r0_d <= ra0;  s0_d <= sa0;
        r2_d <= ra2;  s2_d <= sa2;
        r1_d[0] <= ra1; r1_d[1] <= r1_d[0]; r1_d[2] <= r1_d[1];
        s1_d[0] <= sa1; s1_d[1] <= s1_d[0]; s1_d[2] <= s1_d[1];
    end
    assign res0 = res_m[0][r0_d][15:0];
    assign sb0  = sb_m[0][s0_d][15:0];
    assign res1 = res_m[1][r1_d[2]][15:0];
    assign sb1  = sb_m[1][s1_d[2]][15:0];
    assign res2 = res_m[2][r2_d];
    assign sb2  = sb_m[2][s2_d];

    function automatic wr_t mk_wr(input int id, input int addr, input logic [31:0] y, input int c);
        wr_t w;
        w.id = id; w.addr = addr; w.y = y; w.cyc = c;
        return w;
    endfunction

    function automatic dn_t mk_dn(input int id, input int c);
        dn_t d;
        d.id = id; d.cyc = c;
        return d;
    endfunction

    // observe writes and done pulses away from the active edge
    always @(negedge clk) begin
        if (wen0 === 1'b1) wq.push_back(mk_wr(0, int'(ya0), {16'h0, y0}, cyc));
        if (wen1 === 1'b1) wq.push_back(mk_wr(1, int'(ya1), {16'h0, y1}, cyc));
        if (wen2 === 1'b1) wq.push_back(mk_wr(2, int'(ya2), y2, cyc));
        if (done0 === 1'b1) dq.push_back(mk_dn(0, cyc));
        if (done1 === 1'b1) dq.push_back(mk_dn(1, cyc));
        if (done2 === 1'b1) dq.push_back(mk_dn(2, cyc));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int id, input logic v);
        case (id)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    // raise start so it is sampled on `hold` consecutive edges; t0 = accept edge
    task automatic pulse(input int id, input int hold, output int t0);
        @(posedge clk); #1;
        set_start(id, 1'b1);
        @(posedge clk); #1;
        t0 = cyc;
        repeat (hold - 1) @(posedge clk);
        #1 set_start(id, 1'b0);
    endtask

    task automatic wait_done(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (dq.size() >= n) break;
        end
        chk("done_timeout", (i < budget), 1'b1);
        repeat (8) @(negedge clk);
    endtask

    // reference: word k of run r is written RD_LAT+1 edges after address k,
    // done follows WORDS+RD_LAT+2 edges after accept, back-to-back runs one edge after done
    task automatic verify(input int id, input int t0, input int nruns);
        int lat, period, r, k, ts;
        lat    = (id == 1) ? 3 : 1;
        period = 4 + lat + 3;
        chk("n_writes", wq.size(), nruns * 4);
        chk("n_done", dq.size(), nruns);
        for (int j = 0; j < wq.size() && j < nruns * 4; j++) begin
            r  = j / 4;
            k  = j % 4;
            ts = t0 + r * period;
            chk("wr_inst", wq[j].id, id);
            chk("wr_addr", wq[j].addr, k);
            chk("wr_data", wq[j].y, res_m[id][k] ^ sb_m[id][k]);
            chk("wr_cycle", wq[j].cyc, ts + k + lat + 1);
        end
        for (int j = 0; j < dq.size() && j < nruns; j++) begin
            chk("done_inst", dq[j].id, id);
            chk("done_cycle", dq[j].cyc, t0 + j * period + 4 + lat + 2);
        end
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_busy"}, busy0, 1'b0);
        chk({pfx, "_done"}, done0, 1'b0);
        chk({pfx, "_res_addr"}, ra0, 2'd0);
        chk({pfx, "_sb_addr"}, sa0, 2'd0);
        chk({pfx, "_y_addr"}, ya0, 2'd0);
        chk({pfx, "_y"}, y0, 16'h0);
        chk({pfx, "_y_wen"}, wen0, 1'b0);
    endtask

    initial begin
        int t0;
        int i;
        logic [15:0] res_init [4];
        logic [15:0] sb_init  [4];
        res_init = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        sb_init  = '{16'h00FF, 16'h0F0F, 16'hFFFF, 16'h0000};
        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            res_m[0][k] = {16'h0, res_init[k]};
            sb_m[0][k]  = {16'h0, sb_init[k]};
            res_m[1][k] = 32'h0000_A5A5;
            sb_m[1][k]  = 32'h0000_5A5A;
            res_m[2][k] = $urandom;
            sb_m[2][k]  = res_m[2][k];
        end
        #1;
        chk_zero_outputs("reset");
        chk("reset_wen1", wen1, 1'b0);
        chk("reset_wen2", wen2, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // single pulsed run, spec data
        wq.delete(); dq.delete();
        pulse(0, 1, t0);
        wait_done(1, 60);
        verify(0, t0, 1);
        chk("y_word3", wq.size() > 3 ? wq[3].y : 32'hDEAD_BEEF, 32'h0000_0708);

        // start held: two back-to-back runs
        wq.delete(); dq.delete();
        pulse(0, 12, t0);
        wait_done(2, 80);
        verify(0, t0, 2);

        // extra start during S_READ is ignored
        wq.delete(); dq.delete();
        pulse(0, 1, t0);
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        wait_done(1, 60);
        verify(0, t0, 1);

        // reset after the 2nd write kills the run
        wq.delete(); dq.delete();
        pulse(0, 1, t0);
        for (i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (wq.size() >= 2) break;
        end
        chk("rst_wait", (i < 40), 1'b1);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrun_rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_rst_writes", wq.size(), 2);
        chk("post_rst_done", dq.size(), 0);
        wq.delete(); dq.delete();
        pulse(0, 1, t0);
        wait_done(1, 60);
        verify(0, t0, 1);

        // RD_LAT=3 instance
        wq.delete(); dq.delete();
        pulse(1, 1, t0);
        wait_done(1, 60);
        verify(1, t0, 1);
        chk("lat3_y", wq.size() > 0 ? wq[0].y : 32'h0, 32'h0000_FFFF);

        // 4-element words, res == sb gives zero
        wq.delete(); dq.delete();
        pulse(2, 1, t0);
        wait_done(1, 60);
        verify(2, t0, 1);
        for (int j = 0; j < wq.size(); j++) begin
            chk("wide_zero", wq[j].y, 32'h0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
